if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32 core. It sits directly upstream of the hazard detection unit and consumes its `PC_EN_IF`, `reg_FD_stall` and `reg_FD_flush` outputs. It fetches through a variable-latency instruction-memory port with one request outstanding at a time. It presents `PC_ID`, `inst_ID` and `valid_ID` to the decode stage, honouring stalls, branch redirects and responses to killed (wrong-path) requests.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `NOP`, default 32'h0000_0013: instruction injected as a bubble (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `PC_EN_IF` in 1: permission to issue a new fetch; 0 during a load-use stall.
- `reg_FD_stall` in 1: hold the IF/ID register.
- `reg_FD_flush` in 1: the branch in ID is taken; squash IF/ID and redirect.
- `jump_PC_ID` in 32: redirect target, valid while `reg_FD_flush` is 1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `PC_IF`.
- `imem_gnt` in 1: memory accepts the request in this cycle.
- `imem_rvalid` in 1: response valid; arrives one or more cycles after the grant.
- `imem_rdata` in 32: instruction word.
- `PC_IF` out 32: current fetch PC.
- `PC_ID` out 32: PC of the instruction in ID.
- `inst_ID` out 32: instruction in ID.
- `valid_ID` out 1: `inst_ID` is a real instruction, not a bubble.

## Operation
- Internal `redirect = reg_FD_flush & ~reg_FD_stall`. A stall has priority: a flush during a stall is ignored and must be re-asserted by the hazard detection unit.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, response to be used.
  - DRAIN: one request outstanding, response to be discarded.
- Skid buffer: one entry (`buf_valid`, `buf_inst`, `buf_pc`). It captures a response that arrives while `reg_FD_stall` is 1.
- `imem_req = rst_n & PC_EN_IF & ~redirect & ~buf_valid & (IDLE | (WAIT & imem_rvalid & ~reg_FD_stall))`. This allows back-to-back fetches at one instruction per cycle when memory latency is 1.
- `imem_req` may depend combinationally on `imem_rvalid`. `imem_gnt` is ignored when `imem_req` is 0.
- On `imem_req & imem_gnt`:
  - Latch the issued PC as `req_pc`.
  - `PC_IF <= PC_IF + 4`, wrapping modulo 2^32.
  - Next state is WAIT.
- On `redirect`:
  - `PC_IF <= jump_PC_ID` and the buffer is cleared.
  - If a request is outstanding, or is granted in this same cycle, next state is DRAIN.
  - Otherwise next state is IDLE.
- WAIT with `imem_rvalid` and no new grant: next state is IDLE.
- DRAIN with `imem_rvalid`: the data is dropped and next state is IDLE. No requests are issued while in DRAIN. A further redirect in DRAIN stays in DRAIN and updates `PC_IF`.
- IF/ID register, evaluated in this priority order:
  1. `reg_FD_stall` = 1: hold all outputs. A WAIT-state `imem_rvalid` is written into the buffer (`buf_pc = req_pc`).
  2. `reg_FD_flush` = 1: load `NOP`, `valid_ID = 0`, `PC_ID` unchanged.
  3. `buf_valid` = 1: load the buffer contents, `valid_ID = 1`, clear the buffer.
  4. WAIT & `imem_rvalid`: load `imem_rdata` and `req_pc`, `valid_ID = 1`.
  5. Otherwise: load `NOP`, `valid_ID = 0`.
- No instruction is ever duplicated or lost. The buffer never overflows, because no request issues while it is full.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - `PC_IF = RESET_PC`, state IDLE, `buf_valid = 0`.
  - `PC_ID = 0`, `inst_ID = NOP`, `valid_ID = 0`.
  - `imem_req = 0`.
- First request is raised in the first cycle after `rst_n` rises.
- Latency is grant-to-`valid_ID` = memory latency L. With L = 1, the first instruction is in ID two edges after the first grant, then one per cycle.
- A redirect at edge N puts `imem_addr = jump_PC_ID` in cycle N+1 if no request is outstanding.
- Reset asserted mid-request drops any outstanding response. Responses arriving in IDLE after reset are ignored.

## Test plan
- Reset, L = 1, always grant:
  - `imem_addr` issues 0x0, 0x4, 0x8 on consecutive cycles.
  - `PC_ID` = 0x0 with `valid_ID` = 1 two cycles after reset release.
- L = 3 latency:
  - `imem_req` stays low in WAIT.
  - `valid_ID` pulses once per instruction, with NOP bubbles in between.
- `reg_FD_stall` = 1 for 3 cycles while a response for 0x8 arrives:
  - The response is buffered and `PC_ID`/`inst_ID` are held.
  - After release, `PC_ID` = 0x8 with the correct instruction; no request is issued while the buffer is full.
- `reg_FD_flush` with `jump_PC_ID` = 0x100 while a request for 0x10 is outstanding:
  - The 0x10 data is never seen in ID.
  - The next `imem_addr` is 0x100, and `valid_ID` = 0 in the flush cycle.
- `reg_FD_flush` and `reg_FD_stall` asserted together:
  - IF/ID holds and `PC_IF` is unchanged.
- `rst_n` pulsed low while in WAIT:
  - All outputs return to their reset values immediately.
  - A late `imem_rvalid` is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Single-outstanding imem port, one-entry skid buffer for stalls.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   PC_EN_IF                   permission to issue a new fetch
//   reg_FD_stall, reg_FD_flush hold / squash+redirect IF/ID
//   jump_PC_ID                 redirect target while flushing
//   imem_req/addr/gnt          fetch request handshake
//   imem_rvalid/rdata          fetch response
//   PC_IF                      current fetch PC
//   PC_ID, inst_ID, valid_ID   IF/ID register contents
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic [31:0] jump_PC_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_inst_id;
    logic        r_valid_id;

    logic        w_redirect;
    logic        w_rsp;
    logic        w_fire;
    logic        w_pending;

    // A stall masks the flush; the hazard unit re-asserts it later.
    assign w_redirect = reg_FD_flush & ~reg_FD_stall;

    // Response belonging to a live (not killed) request.
    assign w_rsp = (r_state == S_WAIT) & imem_rvalid;

    // Re-issue in the response cycle gives 1 IPC at latency 1.
    assign imem_req = rst_n & PC_EN_IF & ~w_redirect & ~r_buf_valid
                    & ((r_state == S_IDLE) | (w_rsp & ~reg_FD_stall));

    assign w_fire = imem_req & imem_gnt;

    // Request still in flight after this cycle.
    assign w_pending = (r_state != S_IDLE) & ~imem_rvalid;

    assign imem_addr = r_pc;
    assign PC_IF     = r_pc;
    assign PC_ID     = r_pc_id;
    assign inst_ID   = r_inst_id;
    assign valid_ID  = r_valid_id;

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = w_pending ? S_DRAIN : S_IDLE;
        end else if (w_fire) begin
            w_state_nxt = S_WAIT;
        end else if (imem_rvalid && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_pc <= jump_PC_ID;
            end else if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_fire) begin
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_inst  <= NOP;
            r_buf_pc    <= 32'd0;
        end else if (w_redirect) begin
            r_buf_valid <= 1'b0;
        end else if (reg_FD_stall) begin
            if (w_rsp) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= imem_rdata;
                r_buf_pc    <= r_req_pc;
            end
        end else if (r_buf_valid) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_id    <= 32'd0;
            r_inst_id  <= NOP;
            r_valid_id <= 1'b0;
        end else if (reg_FD_stall) begin
            r_pc_id    <= r_pc_id;
        end else if (reg_FD_flush) begin
            r_inst_id  <= NOP;
            r_valid_id <= 1'b0;
        end else if (r_buf_valid) begin
            r_pc_id    <= r_buf_pc;
            r_inst_id  <= r_buf_inst;
            r_valid_id <= 1'b1;
        end else if (w_rsp) begin
            r_pc_id    <= r_req_pc;
            r_inst_id  <= imem_rdata;
            r_valid_id <= 1'b1;
        end else begin
            r_inst_id  <= NOP;
            r_valid_id <= 1'b0;
        end
    end

endmodule
